// File: rtl/axis_sha3_block_packer.sv
// Packs AXI4-Stream message beats little-endian into SHA3 absorb blocks,
// appends the 0x06..0x80 domain padding on TLAST and hands blocks to the Keccak core.
module axis_sha3_block_packer #(
   parameter int DATA_WIDTH = 16,
   parameter int RATE_BITS  = 1088
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    S_TVALID,
   output logic                    S_TREADY,
   input  logic [DATA_WIDTH-1:0]   S_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
   input  logic                    S_TLAST,
   output logic [RATE_BITS-1:0]    blk_data,
   output logic                    blk_valid,
   input  logic                    blk_ready,
   output logic                    blk_last,
   output logic                    tkeep_err
);

   localparam int KB = DATA_WIDTH / 8;
   localparam int RB = RATE_BITS / 8;
   localparam int PW = $clog2(RB + KB + 1);
   localparam logic [RATE_BITS-1:0] PAD_BLOCK = {8'h80, {(RATE_BITS-16){1'b0}}, 8'h06};

   typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_t;

   state_t                 state;
   logic [PW-1:0]          ptr;
   logic                   pad_pending;

   logic [PW-1:0]          cnt;
   logic [PW-1:0]          new_ptr;
   logic                   keep_bad;
   logic                   beat_fire;
   logic                   block_full;
   logic [RATE_BITS-1:0]   fill_data;

   assign beat_fire  = S_TVALID && S_TREADY;
   assign new_ptr    = ptr + cnt;
   assign block_full = (new_ptr >= PW'(RB));

   always_comb begin
      cnt = '0;
      for (int k = 0; k < KB; k++) begin
         cnt = cnt + PW'(S_TKEEP[k]);
      end
   end

   // Non-contiguous keep, or a partial beat that is not the message tail.
   assign keep_bad = ((S_TKEEP & (S_TKEEP + KB'(1))) != '0) ||
                     (!S_TLAST && (S_TKEEP != '1));

   // Bytes are taken from the low end of the beat, popcount(TKEEP) of them.
   always_comb begin
      fill_data = blk_data;
      for (int k = 0; k < KB; k++) begin
         if ((k < int'(cnt)) && ((int'(ptr) + k) < RB)) begin
            fill_data[8*(int'(ptr)+k) +: 8] = S_TDATA[8*k +: 8];
         end
      end
      if (S_TLAST && !block_full) begin
         fill_data[8*int'(new_ptr) +: 8] = fill_data[8*int'(new_ptr) +: 8] ^ 8'h06;
         fill_data[RATE_BITS-8 +: 8]     = fill_data[RATE_BITS-8 +: 8] ^ 8'h80;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state       <= FILL;
         ptr         <= '0;
         pad_pending <= 1'b0;
         S_TREADY    <= 1'b0;
         blk_valid   <= 1'b0;
         blk_last    <= 1'b0;
         blk_data    <= '0;
         tkeep_err   <= 1'b0;
      end else begin
         if (beat_fire && keep_bad) begin
            tkeep_err <= 1'b1;
         end
         case (state)
            FILL: begin
               S_TREADY <= 1'b1;
               if (beat_fire) begin
                  blk_data <= fill_data;
                  ptr      <= new_ptr;
                  if (S_TLAST || block_full) begin
                     state       <= EMIT;
                     S_TREADY    <= 1'b0;
                     blk_valid   <= 1'b1;
                     blk_last    <= S_TLAST && !block_full;
                     pad_pending <= S_TLAST && block_full;
                  end
               end
            end
            EMIT: begin
               if (blk_ready) begin
                  ptr <= '0;
                  if (pad_pending) begin
                     state    <= EMIT_PAD;
                     blk_data <= PAD_BLOCK;
                     blk_last <= 1'b1;
                  end else begin
                     state     <= FILL;
                     blk_data  <= '0;
                     blk_valid <= 1'b0;
                     blk_last  <= 1'b0;
                     S_TREADY  <= 1'b1;
                  end
               end
            end
            EMIT_PAD: begin
               if (blk_ready) begin
                  state       <= FILL;
                  pad_pending <= 1'b0;
                  blk_data    <= '0;
                  blk_valid   <= 1'b0;
                  blk_last    <= 1'b0;
                  S_TREADY    <= 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
